// File: rtl/matmul_sequencer_if.sv
// -----------------------------------------------------------------------------
// matmul_sequencer_if
// Host-side bus of the matrix-multiply sequencer.
//   wr_en/wr_sel/wr_row/wr_col/wr_data : operand element write (sel 0 = A, 1 = B)
//   start                              : begin a multiply with the buffered A/B
//   busy                               : run in progress (after start, through done)
//   done                               : one-cycle pulse, res_matrix valid
//   res_matrix                         : captured product, index i*N+j = C[i][j]
// master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface matmul_sequencer_if #(
    parameter int DATA_SIZE   = 16,
    parameter int MATRIX_SIZE = 3
);
    localparam int IW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    logic                 wr_en;
    logic                 wr_sel;
    logic [IW-1:0]        wr_row;
    logic [IW-1:0]        wr_col;
    logic [DATA_SIZE-1:0] wr_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [DATA_SIZE-1:0] res_matrix [MATRIX_SIZE*MATRIX_SIZE-1:0];

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, res_matrix
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, res_matrix
    );
endinterface

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
// Controller for an N x N output-stationary systolic multiply array. Buffers
// operands A and B written by the host, clears the array, feeds the skewed
// operand wavefront, flushes the pipeline, captures the product and pulses done.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   host       : host bus (see matmul_sequencer_if), slave side
//   arr_reset  : array accumulator clear (registered)
//   arr_in_a   : array row inputs, lane i feeds row i (registered)
//   arr_in_b   : array column inputs, lane j feeds column j (registered)
//   arr_out    : array accumulators, index i*N+j = C[i][j]
// -----------------------------------------------------------------------------
module matmul_sequencer #(
    parameter int DATA_SIZE   = 16,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    matmul_sequencer_if.slave    host,
    output logic                 arr_reset,
    output logic [DATA_SIZE-1:0] arr_in_a [MATRIX_SIZE-1:0],
    output logic [DATA_SIZE-1:0] arr_in_b [MATRIX_SIZE-1:0],
    input  logic [DATA_SIZE-1:0] arr_out  [MATRIX_SIZE*MATRIX_SIZE-1:0]
);
    localparam int N  = MATRIX_SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(2 * N);
    localparam logic [TW-1:0] FEED_LAST  = TW'(2 * N - 2);
    localparam logic [TW-1:0] FLUSH_LAST = TW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FEED    = 3'd2,
        S_FLUSH   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        t_q, t_d;
    logic                 arr_reset_q, arr_reset_d;
    logic [DATA_SIZE-1:0] a_q   [N-1:0][N-1:0];
    logic [DATA_SIZE-1:0] a_d   [N-1:0][N-1:0];
    logic [DATA_SIZE-1:0] b_q   [N-1:0][N-1:0];
    logic [DATA_SIZE-1:0] b_d   [N-1:0][N-1:0];
    logic [DATA_SIZE-1:0] res_q [N*N-1:0];
    logic [DATA_SIZE-1:0] res_d [N*N-1:0];

    // Next-state and cycle counter.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                t_d = '0;
                if (host.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == FEED_LAST) begin
                    state_d = S_FLUSH;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (t_q == FLUSH_LAST) begin
                    state_d = S_CAPTURE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Operand buffers accept writes only while idle; out-of-range
    // coordinates match no element and are dropped.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (state_q == S_IDLE && host.wr_en) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (host.wr_row == IW'(r) && host.wr_col == IW'(c)) begin
                        if (host.wr_sel) begin
                            b_d[r][c] = host.wr_data;
                        end else begin
                            a_d[r][c] = host.wr_data;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        res_d = res_q;
        if (state_q == S_CAPTURE) res_d = arr_out;
    end

    // Array-side outputs are registered, so they are derived from the state
    // and counter being entered, not the current ones.
    assign arr_reset_d = (state_d == S_CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            arr_reset_q <= 1'b1;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
            for (int e = 0; e < N * N; e++) begin
                res_q[e] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            arr_reset_q <= arr_reset_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
        end
    end

    // Skewed wavefront: in feed step t, row lane i carries A[i][t-i] and
    // column lane j carries B[t-j][j]; lanes outside their window carry 0.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DATA_SIZE-1:0] lane_a_q, lane_a_d;
        logic [DATA_SIZE-1:0] lane_b_q, lane_b_d;

        always_comb begin
            lane_a_d = '0;
            lane_b_d = '0;
            if (state_d == S_FEED) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_d) == gi + k) begin
                        lane_a_d = a_q[gi][k];
                        lane_b_d = b_q[k][gi];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                lane_a_q <= '0;
                lane_b_q <= '0;
            end else begin
                lane_a_q <= lane_a_d;
                lane_b_q <= lane_b_d;
            end
        end

        assign arr_in_a[gi] = lane_a_q;
        assign arr_in_b[gi] = lane_b_q;
    end

    for (genvar gi = 0; gi < N * N; gi++) begin : g_res
        assign host.res_matrix[gi] = res_q[gi];
    end

    assign arr_reset = arr_reset_q;
    assign host.busy = (state_q != S_IDLE);
    assign host.done = (state_q == S_DONE);
endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
// Drives the sequencer through directed and randomized runs. A simple
// output-stationary systolic array sits on the array ports; expected products
// come from a plain matrix-multiply reference on the bench's own copy of A/B.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;
    localparam int DW = 16;
    localparam int N  = 3;
    localparam int IW = $clog2(N);
    localparam logic [63:0] MASK = (64'd1 << DW) - 64'd1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matmul_sequencer_if #(.DATA_SIZE(DW), .MATRIX_SIZE(N)) bus ();

    logic          arr_reset;
    logic [DW-1:0] arr_in_a [N-1:0];
    logic [DW-1:0] arr_in_b [N-1:0];
    logic [DW-1:0] arr_out  [N*N-1:0];

    matmul_sequencer #(.DATA_SIZE(DW), .MATRIX_SIZE(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (bus),
        .arr_reset (arr_reset),
        .arr_in_a  (arr_in_a),
        .arr_in_b  (arr_in_b),
        .arr_out   (arr_out)
    );

    // ---------------- systolic array environment model ----------------
    logic [DW-1:0] pa  [N-1:0][N-1:0];
    logic [DW-1:0] pb  [N-1:0][N-1:0];
    logic [DW-1:0] acc [N-1:0][N-1:0];
    logic [DW-1:0] a_w [N-1:0][N-1:0];
    logic [DW-1:0] b_w [N-1:0][N-1:0];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_w[i][0] = arr_in_a[i];
            b_w[0][i] = arr_in_b[i];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                a_w[i][j] = pa[i][j-1];
                b_w[j][i] = pb[j-1][i];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_reset) begin
                    acc[i][j] <= '0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + a_w[i][j] * b_w[i][j];
                    pa[i][j]  <= a_w[i][j];
                    pb[i][j]  <= b_w[i][j];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                arr_out[i*N+j] = acc[i][j];
            end
        end
    end

    // ---------------- reference model and checking ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned ma [N][N];
    int unsigned mb [N][N];
    int unsigned sa [N][N];
    int unsigned sb [N][N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_c(input int i, input int j);
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        return 64'(s) & MASK;
    endfunction

    function automatic logic [63:0] exp_a(input int t, input int i);
        int k = t - i;
        if (k >= 0 && k < N) return 64'(ma[i][k]);
        return 64'd0;
    endfunction

    function automatic logic [63:0] exp_b(input int t, input int j);
        int k = t - j;
        if (k >= 0 && k < N) return 64'(mb[k][j]);
        return 64'd0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_elem(input bit sel, input int r, input int c, input int unsigned v);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = IW'(r);
        bus.wr_col  = IW'(c);
        bus.wr_data = DW'(v);
        tick();
        bus.wr_en = 1'b0;
        if (sel) mb[r][c] = v;
        else     ma[r][c] = v;
    endtask

    task automatic load_staged(input bit do_a, input bit do_b);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (do_a) write_elem(1'b0, r, c, sa[r][c]);
                if (do_b) write_elem(1'b1, r, c, sb[r][c]);
            end
        end
    endtask

    // One multiply, started from a negedge in an idle cycle; returns at a
    // negedge in the idle cycle after done (or after the injected reset).
    task automatic run(input string tag, input bit inject, input bit do_reset,
                       input bit with_wr, input bit wsel, input int wr, input int wc,
                       input int unsigned wv);
        int lat;
        int pulses;
        bus.start = 1'b1;
        if (with_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = wsel;
            bus.wr_row  = IW'(wr);
            bus.wr_col  = IW'(wc);
            bus.wr_data = DW'(wv);
        end
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (with_wr) begin
            if (wsel) mb[wr][wc] = wv;
            else      ma[wr][wc] = wv;
        end
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (lat == 1) begin
                check({tag, "_clear_busy"}, 64'(bus.busy), 64'd1);
                check({tag, "_clear_arr_reset"}, 64'(arr_reset), 64'd1);
            end else if (lat <= 2 * N) begin
                for (int i = 0; i < N; i++) begin
                    check($sformatf("%s_feed_t%0d_a%0d", tag, lat - 2, i), 64'(arr_in_a[i]), exp_a(lat - 2, i));
                    check($sformatf("%s_feed_t%0d_b%0d", tag, lat - 2, i), 64'(arr_in_b[i]), exp_b(lat - 2, i));
                end
            end else if (lat <= 3 * N) begin
                check({tag, "_flush_a0"}, 64'(arr_in_a[0]), 64'd0);
                check({tag, "_flush_arr_reset"}, 64'(arr_reset), 64'd0);
            end
            if (do_reset && lat == 4) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        ma[r][c] = 0;
                        mb[r][c] = 0;
                    end
                check({tag, "_rst_busy"}, 64'(bus.busy), 64'd0);
                for (int i = 0; i < N; i++) begin
                    check($sformatf("%s_rst_a%0d", tag, i), 64'(arr_in_a[i]), 64'd0);
                    check($sformatf("%s_rst_b%0d", tag, i), 64'(arr_in_b[i]), 64'd0);
                end
                for (int e = 0; e < N * N; e++)
                    check($sformatf("%s_rst_res%0d", tag, e), 64'(bus.res_matrix[e]), 64'd0);
                pulses = 0;
                for (int c = 0; c < 14; c++) begin
                    if (bus.done === 1'b1) pulses++;
                    tick();
                end
                check({tag, "_rst_no_done"}, 64'(pulses), 64'd0);
                $display("run %s: reset asserted in feed t=2", tag);
                return;
            end
            if (inject && lat == 5) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_row  = '0;
                bus.wr_col  = '0;
                bus.wr_data = DW'(50);
                bus.start   = 1'b1;
            end
            tick();
            lat++;
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
        end
        check({tag, "_latency"}, 64'(lat), 64'(3 * N + 2));
        check({tag, "_done_busy"}, 64'(bus.busy), 64'd1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), 64'(bus.res_matrix[i*N+j]), ref_c(i, j));
        $display("run %s: latency %0d C00=%0d C%0d%0d=%0d", tag, lat,
                 bus.res_matrix[0], N - 1, N - 1, bus.res_matrix[N*N-1]);
        tick();
        check({tag, "_idle_done"}, 64'(bus.done), 64'd0);
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
            end
        repeat (3) tick();
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_arr_reset", 64'(arr_reset), 64'd1);
        check("reset_a0", 64'(arr_in_a[0]), 64'd0);
        check("reset_b2", 64'(arr_in_b[2]), 64'd0);
        check("reset_res0", 64'(bus.res_matrix[0]), 64'd0);
        reset = 1'b0;
        tick();
        check("post_reset_arr_reset", 64'(arr_reset), 64'd0);
        check("post_reset_busy", 64'(bus.busy), 64'd0);

        // Worked example.
        sa = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        sb = '{'{2, 1, 3}, '{4, 5, 7}, '{6, 9, 8}};
        load_staged(1'b1, 1'b1);
        run("given", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("given_c00_lit", 64'(bus.res_matrix[0]), 64'd28);
        check("given_c22_lit", 64'(bus.res_matrix[8]), 64'd149);

        // Identity A, repeated without new writes (second start back-to-back).
        sa = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
        load_staged(1'b1, 1'b0);
        run("ident", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run("ident_rep", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("ident_c12_lit", 64'(bus.res_matrix[5]), 64'd7);

        // Write and start while busy must both be ignored.
        run("busy_inj", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        check("busy_inj_extra_done", 64'(pulses), 64'd0);
        run("busy_inj_after", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("busy_inj_a00_kept", 64'(bus.res_matrix[0]), 64'd2);

        // Reset in the middle of feeding, then a fresh run.
        sa = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        load_staged(1'b1, 1'b0);
        run("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                sa[r][c] = $urandom_range(0, 255);
                sb[r][c] = $urandom_range(0, 255);
            end
        load_staged(1'b1, 1'b1);
        run("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // All-ones operands exercise wrap-around.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                sa[r][c] = int'(MASK);
                sb[r][c] = int'(MASK);
            end
        load_staged(1'b1, 1'b1);
        run("ones", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("ones_c11_lit", 64'(bus.res_matrix[4]), 64'd3);

        // Random operands, a write merged with start, then a back-to-back repeat.
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    sa[r][c] = $urandom & int'(MASK);
                    sb[r][c] = $urandom & int'(MASK);
                end
            load_staged(1'b1, 1'b1);
            run($sformatf("rnd%0d", it), 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)),
                $urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom & int'(MASK));
            run($sformatf("rnd%0d_b2b", it), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Controller that owns a MATRIX_SIZE×MATRIX_SIZE systolic matrix-multiply array. It buffers operands A and B written by a host, clears the array, and drives the row/column-skewed operand wavefront into it. It then flushes the pipeline, captures the product matrix into a result register and signals completion. This replaces hand-sequenced stimulus with a reusable block between the host/bus logic and the array.

## Interface
- DATA_SIZE, 16, width of every operand, array lane and result element
- MATRIX_SIZE, 3, N; square matrix dimension (N ≥ 2)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  operand write strobe
- wr_sel  in  1  0 = write A, 1 = write B
- wr_row, wr_col  in  $clog2(N) each  element coordinates
- wr_data  in  DATA_SIZE  element value
- start  in  1  begin a multiply using current A/B buffers
- busy  out  1  high from the cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, result valid
- arr_reset  out  1  drives array reset
- arr_in_a  out  N×DATA_SIZE  array row inputs, unpacked [N-1:0]
- arr_in_b  out  N×DATA_SIZE  array column inputs, unpacked [N-1:0]
- arr_out  in  N·N×DATA_SIZE  array accumulators, index i·N+j = C[i][j]
- res_matrix  out  N·N×DATA_SIZE  captured product, same indexing

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, CAPTURE, DONE; cycle counter t of width $clog2(2N).
- IDLE: busy=0. start=1 → CLEAR. wr_en=1 writes A[wr_row][wr_col] or B[...] next edge.
- wr_en while busy=1 ignored (buffers unchanged). start while busy=1 ignored.
- wr_en and start in the same IDLE cycle: write takes effect and is used by that run.
- CLEAR: 1 cycle, arr_reset=1, t←0 → FEED.
- FEED: 2N-1 cycles, t=0..2N-2. arr_in_a[i]=A[i][t-i] and arr_in_b[j]=B[t-j][j] when 0≤t-i<N (resp. t-j), else 0. At t=2N-2 → FLUSH, t←0.
- FLUSH: N cycles, all arr_in_* = 0, arr_reset=0 → CAPTURE.
- CAPTURE: 1 cycle, res_matrix←arr_out on its closing edge → DONE.
- DONE: 1 cycle, done=1, busy=1 → IDLE. A start in DONE is ignored.
- Arithmetic belongs to the array. Products and sums wrap modulo 2^DATA_SIZE; the sequencer does no width extension.
- Buffers are retained across runs, so an identical start repeats the result.

## Timing
- arr_in_a/arr_in_b/arr_reset are registered and change only on rising edges. They are valid in the cycle of the state that owns them.
- start sampled at edge k: CLEAR in cycle k+1, FEED cycles k+2..k+2N, FLUSH k+2N+1..k+3N, CAPTURE k+3N+1, done=1 in cycle k+3N+2. For N=3, done is high 11 cycles after the start edge.
- Back-to-back: next start is accepted in the IDLE cycle immediately after DONE.
- Reset values: state=IDLE, busy=0, done=0, arr_reset=1 while reset is high and 0 after, arr_in_a=arr_in_b=0, res_matrix=0, A=B=0.
- Reset mid-operation (any state): next cycle IDLE with the reset values. No done is pulsed and res_matrix is cleared.
- Outside CLEAR and reset, arr_reset=0. Outside FEED, arr_in_*=0.

## Test plan
- Write A=[1 2 3;4 5 6;7 8 9], B=[2 1 3;4 5 7;6 9 8], start. Check FEED t=0 a={1,0,0} b={2,0,0}; t=1 a={2,4,0} b={4,1,0}; t=2 a={3,5,7} b={6,5,3}; t=4 a={0,0,9} b={0,0,8}. Then res_matrix={28,38,41,64,83,95,100,128,149} with done exactly 11 cycles after start.
- A=identity, B as above → res_matrix equals B. A second start without new writes gives the same result and the same latency.
- During busy, pulse wr_en writing A[0][0]=50 and pulse start. Result is unchanged and there is one done only. A subsequent run uses A[0][0]=1.
- Assert reset in FEED t=2 → busy=0, arr_in_*=0, res_matrix=0, no done. A new start completes correctly.
- Write all-ones values 2^DATA_SIZE-1 into A and B (N=3) → each C element is 3·(2^DATA_SIZE-1)^2 mod 2^DATA_SIZE, confirming wrap.
- Issue start in the IDLE cycle right after done → CLEAR occurs the next cycle and both runs produce correct results.
